m68k_bus_ctrl: RTL and testbench
================================

Name: m68k_bus_ctrl

Overview:
- 68000 bus controller between the fx68k core and the memory/peripheral blocks (ROM, VRAM, RAM/SDRAM, I/O).
- Decodes the address and chip-selects the target.
- Replaces hard-tied DTACKn/VPAn/BERRn with real handshakes: per-region wait states, optional external RAM ready, autovectored interrupt acknowledge and bus-error timeout.

Parameters:
- C_ROM_WAIT, 1, clk cycles between decode and DTACKn low for ROM (addr[17:15] 0..1), 0..15
- C_VRAM_WAIT, 1, wait cycles for VRAM (addr[17:15]==2), 0..15
- C_RAM_WAIT, 0, wait cycles for RAM (addr[17:15]>=3), 0..15
- C_IO_WAIT, 2, wait cycles for I/O (addr[23:16]==8'hFF), 0..15
- C_RAM_EXT_READY, 0, 1: RAM waits for ram_ready instead of C_RAM_WAIT
- C_TIMEOUT, 255, clk cycles in WAIT before bus error (only with BUS_TIMEOUT_EN), 1..255

Ports:
- clk  in  1  CPU clock (same clock as fx68k)
- reset  in  1  asynchronous, active-high
- as_n  in  1  CPU address strobe
- rw  in  1  1=read, 0=write
- uds_n  in  1  upper data strobe
- lds_n  in  1  lower data strobe
- addr  in  23  CPU address [23:1]
- fc  in  3  function code {FC2,FC1,FC0}
- ram_ready  in  1  external RAM/SDRAM done, level, used when C_RAM_EXT_READY=1
- cs_rom  out  1  ROM select
- cs_vram  out  1  VRAM select
- cs_ram  out  1  RAM select
- cs_io  out  1  I/O select
- we  out  1  write strobe: selected && !rw && (!uds_n || !lds_n)
- dtack_n  out  1  data transfer ack to CPU
- vpa_n  out  1  valid peripheral address (autovector)
- berr_n  out  1  bus error to CPU
- busy  out  1  high while state != IDLE

Behaviour:
- Reset values: all cs_* 0, we 0, dtack_n 1, vpa_n 1, berr_n 1, busy 0, state IDLE, counters 0.
- Reset is asynchronous and returns everything to these values even mid-cycle.
- Decode is registered at cycle start, with priority:
  - IACK: fc==3'b111
  - IO: addr[23:16]==8'hFF
  - ROM/VRAM/RAM: addr[23:18]==0, split by addr[17:15]
  - otherwise UNMAPPED
- Exactly one cs_* high from the cycle after AS_n low until return to IDLE. IACK and UNMAPPED raise no cs_*.
- State machine:
  - IDLE: as_n==0 → latch region. IACK → AVEC. Mapped → WAIT, loading wcnt with the region's wait count. UNMAPPED → WAIT, wcnt=0.
  - WAIT: wcnt decrements each clk. When wcnt==0 (or ram_ready==1 for RAM with C_RAM_EXT_READY=1) → ACK. Zero wait means ACK on the next clk, i.e. DTACKn low 2 clk after AS_n low.
  - ACK: dtack_n=0, held until as_n==1 → IDLE, with dtack_n=1 and cs=0 in the same clk.
  - AVEC: vpa_n=0 until as_n==1 → IDLE. No dtack.
  - BERR: berr_n=0 until as_n==1 → IDLE. No dtack.
- as_n rising in WAIT (aborted cycle): → IDLE next clk, no DTACKn pulse, cs cleared.
- as_n already low when IDLE is re-entered (back-to-back strobe): a new cycle starts only after as_n has been seen high for ≥1 clk. An edge flag prevents re-triggering.
- we follows the strobes combinationally from registered cs and rw, so byte writes honour uds_n/lds_n.
- ram_ready asserted before entry to WAIT is accepted on the first WAIT clk.
- dtack_n, vpa_n, berr_n are never low simultaneously.

Optional Feature:
- Macro: BUS_TIMEOUT_EN
- Defined:
  - 8-bit tcnt counts clk in WAIT.
  - Reaching C_TIMEOUT → BERR.
  - UNMAPPED goes to BERR directly instead of ACK.
- Undefined:
  - No timeout counter.
  - UNMAPPED acks after 0 waits (reads return whatever the data mux yields).
  - An RAM ext-ready wait can last indefinitely.

Decomposition:
- Package m68k_bus_pkg holds:
  - region enum (IDLE-region none, ROM, VRAM, RAM, IO, IACK, UNMAPPED)
  - state enum (IDLE, WAIT, ACK, AVEC, BERR)
  - FC_IACK=3'b111 and IO_PAGE=8'hFF constants
- One sub-module, m68k_addr_decode: purely combinational addr/fc → region, reused by the top-level data-read mux.

Test Plan:
- ROM read addr=24'h000100, C_ROM_WAIT=1, as_n low at T0 → cs_rom=1 at T1, dtack_n=0 at T3, dtack_n=1 and cs_rom=0 one clk after as_n high.
- RAM byte write addr=24'h018000, lds_n=0, uds_n=1, rw=0, C_RAM_EXT_READY=1, ram_ready raised 5 clk later → cs_ram=1, we=1, dtack_n=0 one clk after ram_ready.
- IACK with fc=3'b111, addr=24'hFFFFF3 → vpa_n=0 and cs_io=0, dtack_n stays 1, vpa_n released after as_n high.
- BUS_TIMEOUT_EN, C_TIMEOUT=16, access addr=24'h400000 → berr_n=0 one clk after decode, dtack_n never low. RAM ext-ready with ram_ready stuck 0 → berr_n=0 after 16 clk.
- Abort: as_n low, then high again while in WAIT (C_IO_WAIT=2, addr=24'hFF0000) → no dtack pulse, cs_io cleared, busy=0 next clk.
- Reset asserted during ACK → dtack_n=1, cs_*=0 immediately without waiting for clk. After release, as_n still low → no new cycle until as_n goes high then low.

Source files
------------

// File: rtl/m68k_bus_pkg.sv
// ----------------------------------------------------------------------------
// m68k_bus_pkg
// Shared types and constants for the 68000 bus controller slice.
//   region_t : target region decoded from addr/fc at the start of a bus cycle
//   state_t  : bus-cycle state machine states
//   FC_IACK  : function code of an interrupt-acknowledge cycle
//   IO_PAGE  : addr[23:16] value of the I/O page
// ----------------------------------------------------------------------------
package m68k_bus_pkg;

    typedef enum logic [2:0] {
        REG_NONE,
        REG_ROM,
        REG_VRAM,
        REG_RAM,
        REG_IO,
        REG_IACK,
        REG_UNMAPPED
    } region_t;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_WAIT,
        ST_ACK,
        ST_AVEC,
        ST_BERR
    } state_t;

    localparam logic [2:0] FC_IACK = 3'b111;
    localparam logic [7:0] IO_PAGE = 8'hFF;

endpackage

// File: rtl/m68k_addr_decode.sv
// ----------------------------------------------------------------------------
// m68k_addr_decode
// Purely combinational address/function-code decoder.
// Ports:
//   addr_hi  in  9  CPU address bits [23:15] (lower bits never affect region)
//   fc       in  3  function code {FC2,FC1,FC0}
//   region   out    decoded region_t (never REG_NONE)
// Priority: IACK, then I/O page, then ROM/VRAM/RAM in the low 256 KiB,
// everything else is unmapped.
// ----------------------------------------------------------------------------
module m68k_addr_decode
    import m68k_bus_pkg::*;
(
    input  logic [23:15] addr_hi,
    input  logic [2:0]   fc,
    output region_t      region
);

    always_comb begin
        region = REG_UNMAPPED;
        if (fc == FC_IACK) begin
            region = REG_IACK;
        end else if (addr_hi[23:16] == IO_PAGE) begin
            region = REG_IO;
        end else if (addr_hi[23:18] == 6'd0) begin
            case (addr_hi[17:15])
                3'd0, 3'd1: region = REG_ROM;
                3'd2:       region = REG_VRAM;
                default:    region = REG_RAM;
            endcase
        end
    end

endmodule

// File: rtl/m68k_bus_ctrl.sv
// ----------------------------------------------------------------------------
// m68k_bus_ctrl
// 68000 bus controller between the fx68k core and ROM/VRAM/RAM/I/O.
// Decodes the target at cycle start, drives chip selects and generates real
// DTACKn / VPAn / BERRn handshakes with per-region wait states.
// Ports:
//   clk, reset            CPU clock, asynchronous active-high reset
//   as_n, rw, uds_n, lds_n CPU bus strobes and direction
//   addr[23:1], fc         CPU address and function code
//   ram_ready              external RAM done (level), used if C_RAM_EXT_READY
//   cs_rom/vram/ram/io     chip selects (registered)
//   we                     write strobe honouring byte lanes
//   dtack_n, vpa_n, berr_n handshakes to the CPU (registered)
//   busy                   high while the state machine is not IDLE
// Optional feature macro: BUS_TIMEOUT_EN
//   defined   : WAIT is bounded by C_TIMEOUT clocks (-> bus error) and
//               unmapped accesses end in a bus error
//   undefined : no timeout, unmapped accesses ack after zero waits
// ----------------------------------------------------------------------------
module m68k_bus_ctrl #(
    parameter int C_ROM_WAIT      = 1,
    parameter int C_VRAM_WAIT     = 1,
    parameter int C_RAM_WAIT      = 0,
    parameter int C_IO_WAIT       = 2,
    parameter int C_RAM_EXT_READY = 0,
    parameter int C_TIMEOUT       = 255
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        as_n,
    input  logic        rw,
    input  logic        uds_n,
    input  logic        lds_n,
    input  logic [23:1] addr,
    input  logic [2:0]  fc,
    input  logic        ram_ready,
    output logic        cs_rom,
    output logic        cs_vram,
    output logic        cs_ram,
    output logic        cs_io,
    output logic        we,
    output logic        dtack_n,
    output logic        vpa_n,
    output logic        berr_n,
    output logic        busy
);
    import m68k_bus_pkg::*;

    state_t     state;
    region_t    region_q;
    region_t    dec_region;
    logic [3:0] cs_q;
    logic [3:0] wcnt;
    logic [3:0] wait_sel;
    logic       rw_q;
    logic       armed;
    logic       wait_done;
    logic       unused_addr_lo;
`ifdef BUS_TIMEOUT_EN
    logic [7:0] tcnt;
`endif

    assign unused_addr_lo = ^addr[14:1];

    m68k_addr_decode u_decode (
        .addr_hi (addr[23:15]),
        .fc      (fc),
        .region  (dec_region)
    );

    // Wait count loaded on entry to WAIT; unmapped and IACK need none.
    always_comb begin
        wait_sel = 4'd0;
        case (dec_region)
            REG_ROM:  wait_sel = 4'(C_ROM_WAIT);
            REG_VRAM: wait_sel = 4'(C_VRAM_WAIT);
            REG_RAM:  wait_sel = 4'(C_RAM_WAIT);
            REG_IO:   wait_sel = 4'(C_IO_WAIT);
            default:  wait_sel = 4'd0;
        endcase
    end

    // RAM with an external ready ignores the wait counter entirely.
    assign wait_done = (C_RAM_EXT_READY != 0 && region_q == REG_RAM) ? ram_ready
                                                                      : (wcnt == 4'd0);

    assign {cs_rom, cs_vram, cs_ram, cs_io} = cs_q;
    assign busy = (state != ST_IDLE);
    assign we   = (|cs_q) && !rw_q && (!uds_n || !lds_n);

    // Bus-cycle state machine. 'armed' is the edge flag: a new cycle may only
    // start once as_n has been seen high, so a strobe still low when IDLE is
    // re-entered (or after reset) cannot re-trigger the same cycle.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state    <= ST_IDLE;
            region_q <= REG_NONE;
            cs_q     <= 4'b0000;
            rw_q     <= 1'b1;
            wcnt     <= 4'd0;
            armed    <= 1'b0;
            dtack_n  <= 1'b1;
            vpa_n    <= 1'b1;
            berr_n   <= 1'b1;
`ifdef BUS_TIMEOUT_EN
            tcnt     <= 8'd0;
`endif
        end else begin
            if (as_n) begin
                armed <= 1'b1;
            end
            case (state)
                ST_IDLE: begin
                    if (!as_n && armed) begin
                        armed    <= 1'b0;
                        region_q <= dec_region;
                        rw_q     <= rw;
                        cs_q     <= {dec_region == REG_ROM, dec_region == REG_VRAM,
                                     dec_region == REG_RAM, dec_region == REG_IO};
                        if (dec_region == REG_IACK) begin
                            state <= ST_AVEC;
                            vpa_n <= 1'b0;
                        end else begin
                            state <= ST_WAIT;
                            wcnt  <= wait_sel;
`ifdef BUS_TIMEOUT_EN
                            tcnt  <= 8'd0;
`endif
                        end
                    end
                end
                ST_WAIT: begin
                    if (as_n) begin
                        state <= ST_IDLE;
                        cs_q  <= 4'b0000;
                    end else if (wait_done) begin
`ifdef BUS_TIMEOUT_EN
                        if (region_q == REG_UNMAPPED) begin
                            state  <= ST_BERR;
                            berr_n <= 1'b0;
                        end else
`endif
                        begin
                            state   <= ST_ACK;
                            dtack_n <= 1'b0;
                        end
                    end
`ifdef BUS_TIMEOUT_EN
                    else if (tcnt == 8'(C_TIMEOUT - 1)) begin
                        state  <= ST_BERR;
                        berr_n <= 1'b0;
                    end
`endif
                    else begin
                        if (wcnt != 4'd0) begin
                            wcnt <= wcnt - 4'd1;
                        end
`ifdef BUS_TIMEOUT_EN
                        tcnt <= tcnt + 8'd1;
`endif
                    end
                end
                ST_ACK, ST_AVEC, ST_BERR: begin
                    if (as_n) begin
                        state   <= ST_IDLE;
                        cs_q    <= 4'b0000;
                        dtack_n <= 1'b1;
                        vpa_n   <= 1'b1;
                        berr_n  <= 1'b1;
                    end
                end
                default: begin
                    state <= ST_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_m68k_bus_ctrl.sv
// ----------------------------------------------------------------------------
// tb_m68k_bus_ctrl
// Self-checking bench for m68k_bus_ctrl. Each bus cycle pushes its expected
// response (which handshake, how many clocks after as_n low, chip selects)
// onto a scoreboard queue; the entry is popped when the DUT answers.
// Build with BUS_TIMEOUT_EN defined to exercise the bus-error timeout.
// ----------------------------------------------------------------------------
module tb_m68k_bus_ctrl;

    localparam int TIMEOUT = 16;
    localparam logic [8:0] OUTS_IDLE = 9'b0000_0_111_0;

    logic        clk = 1'b0;
    logic        reset;
    logic        as_n;
    logic        rw;
    logic        uds_n;
    logic        lds_n;
    logic [23:0] byte_addr;
    logic [2:0]  fc;
    logic        ram_ready;
    logic        cs_rom, cs_vram, cs_ram, cs_io;
    logic        we, dtack_n, vpa_n, berr_n, busy;

    typedef struct {
        string      tag;
        int         kind;
        int         lat;
        logic [3:0] cs;
        logic       we_exp;
    } exp_t;

    exp_t sb[$];
    int   n_cmp = 0;
    int   n_bad = 0;

    always #5 clk = ~clk;

    m68k_bus_ctrl #(
        .C_ROM_WAIT      (1),
        .C_VRAM_WAIT     (1),
        .C_RAM_WAIT      (0),
        .C_IO_WAIT       (2),
        .C_RAM_EXT_READY (1),
        .C_TIMEOUT       (TIMEOUT)
    ) dut (
        .clk       (clk),
        .reset     (reset),
        .as_n      (as_n),
        .rw        (rw),
        .uds_n     (uds_n),
        .lds_n     (lds_n),
        .addr      (byte_addr[23:1]),
        .fc        (fc),
        .ram_ready (ram_ready),
        .cs_rom    (cs_rom),
        .cs_vram   (cs_vram),
        .cs_ram    (cs_ram),
        .cs_io     (cs_io),
        .we        (we),
        .dtack_n   (dtack_n),
        .vpa_n     (vpa_n),
        .berr_n    (berr_n),
        .busy      (busy)
    );

    task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("[TB] FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        @(negedge clk);
    endtask

    function automatic logic [8:0] outs();
        return {cs_rom, cs_vram, cs_ram, cs_io, we, dtack_n, vpa_n, berr_n, busy};
    endfunction

    function automatic logic [3:0] cs_vec();
        return {cs_rom, cs_vram, cs_ram, cs_io};
    endfunction

    // 0 = dtack, 1 = vpa, 2 = berr, 3 = nothing yet
    function automatic int resp_kind();
        if (!dtack_n) return 0;
        if (!vpa_n)   return 1;
        if (!berr_n)  return 2;
        return 3;
    endfunction

    // Start a bus cycle and wait (bounded) for the handshake. ready_at < 0
    // leaves ram_ready low; otherwise it rises after that many clocks.
    task automatic applyStimulus(input string tag, input logic [23:0] a, input logic [2:0] f,
                                 input logic r, input logic u, input logic l, input int ready_at,
                                 input int kind, input int lat, input logic [3:0] cs_exp,
                                 input logic we_exp);
        exp_t e;
        int   cnt;
        e.tag = tag; e.kind = kind; e.lat = lat; e.cs = cs_exp; e.we_exp = we_exp;
        sb.push_back(e);
        byte_addr = a; fc = f; rw = r; uds_n = u; lds_n = l;
        if (ready_at == 0) ram_ready = 1'b1;
        as_n = 1'b0;
        tick();
        cnt = 1;
        checkOutput({tag, "/busy"}, 32'(busy), 32'd1);
        while (resp_kind() == 3 && cnt < 40) begin
            if (cnt == ready_at) ram_ready = 1'b1;
            tick();
            cnt++;
        end
        e = sb.pop_front();
        checkOutput({e.tag, "/kind"}, 32'(resp_kind()), 32'(e.kind));
        checkOutput({e.tag, "/latency"}, 32'(cnt), 32'(e.lat));
        checkOutput({e.tag, "/cs"}, 32'(cs_vec()), 32'(e.cs));
        checkOutput({e.tag, "/we"}, 32'(we), 32'(e.we_exp));
        checkOutput({e.tag, "/one_strobe"}, 32'(int'(!dtack_n) + int'(!vpa_n) + int'(!berr_n)), 32'd1);
    endtask

    task automatic endCycle(input string tag);
        as_n = 1'b1; uds_n = 1'b1; lds_n = 1'b1;
        tick();
        ram_ready = 1'b0;
        checkOutput({tag, "/release"}, 32'(outs()), 32'(OUTS_IDLE));
    endtask

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: simulation did not finish");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        reset = 1'b1; as_n = 1'b1; rw = 1'b1; uds_n = 1'b1; lds_n = 1'b1;
        fc = 3'b000; byte_addr = 24'h0; ram_ready = 1'b0;
        repeat (2) @(negedge clk);
        checkOutput("reset/outs", 32'(outs()), 32'(OUTS_IDLE));
        reset = 1'b0;
        tick();
        tick();

        applyStimulus("rom_read", 24'h000100, 3'b110, 1'b1, 1'b0, 1'b0, -1, 0, 3, 4'b1000, 1'b0);
        endCycle("rom_read");
        applyStimulus("vram_write", 24'h010000, 3'b101, 1'b0, 1'b0, 1'b0, -1, 0, 3, 4'b0100, 1'b1);
        endCycle("vram_write");
        applyStimulus("io_read", 24'hFF0000, 3'b101, 1'b1, 1'b0, 1'b0, -1, 0, 4, 4'b0001, 1'b0);
        endCycle("io_read");
        applyStimulus("ram_byte_wr", 24'h018000, 3'b101, 1'b0, 1'b1, 1'b0, 5, 0, 6, 4'b0010, 1'b1);
        endCycle("ram_byte_wr");
        applyStimulus("ram_ready_early", 24'h03FFFE, 3'b101, 1'b1, 1'b0, 1'b1, 0, 0, 2, 4'b0010, 1'b0);
        endCycle("ram_ready_early");
        applyStimulus("iack", 24'hFFFFF3, 3'b111, 1'b1, 1'b1, 1'b0, -1, 1, 1, 4'b0000, 1'b0);
        endCycle("iack");
`ifdef BUS_TIMEOUT_EN
        applyStimulus("unmapped", 24'h400000, 3'b101, 1'b1, 1'b0, 1'b0, -1, 2, 2, 4'b0000, 1'b0);
        endCycle("unmapped");
        applyStimulus("ram_stuck", 24'h020000, 3'b101, 1'b1, 1'b0, 1'b0, -1, 2, TIMEOUT + 1, 4'b0010, 1'b0);
        endCycle("ram_stuck");
`else
        applyStimulus("unmapped", 24'h400000, 3'b101, 1'b1, 1'b0, 1'b0, -1, 0, 2, 4'b0000, 1'b0);
        endCycle("unmapped");
`endif

        // Aborted I/O cycle: as_n rises while the wait counter is still running.
        byte_addr = 24'hFF0000; fc = 3'b101; rw = 1'b1; uds_n = 1'b0; lds_n = 1'b0;
        as_n = 1'b0;
        tick();
        checkOutput("abort/cs", 32'(cs_vec()), 32'h1);
        tick();
        checkOutput("abort/no_dtack_yet", 32'(dtack_n), 32'd1);
        as_n = 1'b1; uds_n = 1'b1; lds_n = 1'b1;
        tick();
        checkOutput("abort/idle", 32'(outs()), 32'(OUTS_IDLE));
        tick();
        checkOutput("abort/stays_idle", 32'(outs()), 32'(OUTS_IDLE));

        // Reset in the middle of ACK, then the edge flag after reset.
        byte_addr = 24'h000100; fc = 3'b110; rw = 1'b1; uds_n = 1'b0; lds_n = 1'b0;
        as_n = 1'b0;
        repeat (3) tick();
        checkOutput("rst/in_ack", 32'(dtack_n), 32'd0);
        #2 reset = 1'b1;
        #1 checkOutput("rst/async", 32'(outs()), 32'(OUTS_IDLE));
        #1 reset = 1'b0;
        @(negedge clk);
        tick();
        tick();
        checkOutput("rst/no_retrigger", 32'({cs_vec(), busy}), 32'h0);
        as_n = 1'b1;
        tick();
        as_n = 1'b0;
        tick();
        checkOutput("rst/new_cycle_cs", 32'(cs_vec()), 32'h8);
        tick();
        tick();
        checkOutput("rst/new_cycle_dtack", 32'(dtack_n), 32'd0);
        endCycle("rst/new_cycle");

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
